// File: rtl/upsample_channel_scheduler.sv
// Channel-by-channel sequencer for the upsample engine: one DMA read command per channel,
// pixel pass-through into the engine, and a bounded number of channels in flight.
module upsample_channel_scheduler #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              system_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        cfg_col_size,
  input  logic [9:0]        cfg_row_size,
  input  logic [11:0]       cfg_channels,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [19:0]       rd_cmd_len,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [7:0]        up_feature,
  output logic              up_feature_valid,
  input  logic              up_feature_ready,
  output logic [9:0]        up_col_size,
  output logic [9:0]        up_row_size,
  input  logic              up_channel_ready
);

  typedef enum logic [2:0] {IDLE, CMD, FEED, SLOT, DRAIN, DONE} state_t;

  localparam logic [11:0] MAX_OUT_W = 12'(MAX_OUT);

  state_t      state, state_nx;
  logic [11:0] channels, fed_ch, done_ch, outstanding, out_after;
  logic [19:0] pix_cnt;
  logic        cmd_fire, pix_fire, last_pix, chr_ok, chr_bad, cfg_zero;

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign cmd_fire    = rd_cmd_valid & rd_cmd_ready;
  assign pix_fire    = (state == FEED) & src_valid & up_feature_ready;
  assign last_pix    = pix_fire & (pix_cnt == rd_cmd_len - 20'd1);
  assign outstanding = fed_ch - done_ch;
  // A channel_ready with nothing in flight is a protocol error and is not counted.
  assign chr_ok      = up_channel_ready & busy & (outstanding != 12'd0);
  assign chr_bad     = up_channel_ready & (outstanding == 12'd0);
  assign out_after   = outstanding + 12'd1 - {11'd0, chr_ok};
  assign cfg_zero    = (cfg_col_size == 10'd0) | (cfg_row_size == 10'd0) | (cfg_channels == 12'd0);

  assign up_feature       = src_data;
  assign up_feature_valid = (state == FEED) & src_valid;
  assign src_ready        = (state == FEED) & up_feature_ready;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = cfg_zero ? DONE : CMD;
      CMD:   if (cmd_fire) state_nx = FEED;
      FEED:  if (last_pix) begin
               if (fed_ch + 12'd1 == channels) state_nx = DRAIN;
               else if (out_after < MAX_OUT_W) state_nx = CMD;
               else                            state_nx = SLOT;
             end
      SLOT:  if (outstanding < MAX_OUT_W) state_nx = CMD;
      DRAIN: if (done_ch == channels) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      channels     <= '0;
      fed_ch       <= '0;
      done_ch      <= '0;
      pix_cnt      <= '0;
      cfg_err      <= 1'b0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= '0;
      up_col_size  <= '0;
      up_row_size  <= '0;
    end else begin
      rd_cmd_valid <= (state_nx == CMD);
      if (state == IDLE && start) begin
        up_col_size <= cfg_col_size;
        up_row_size <= cfg_row_size;
        channels    <= cfg_channels;
        rd_cmd_len  <= 20'(cfg_col_size) * 20'(cfg_row_size);
        rd_cmd_addr <= cfg_src_addr;
        fed_ch      <= '0;
        done_ch     <= '0;
        pix_cnt     <= '0;
        cfg_err     <= cfg_zero;
      end else begin
        // Channels are contiguous, so the next command starts where this one ends.
        if (cmd_fire) rd_cmd_addr <= rd_cmd_addr + ADDR_W'(rd_cmd_len);
        if (pix_fire) begin
          if (last_pix) begin
            pix_cnt <= '0;
            fed_ch  <= fed_ch + 12'd1;
          end else begin
            pix_cnt <= pix_cnt + 20'd1;
          end
        end
        if (chr_ok)  done_ch <= done_ch + 12'd1;
        if (chr_bad) cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upsample_channel_scheduler.sv
// Randomized bench: DMA source and upsample engine models drive the scheduler, and a
// transaction-level model (command list, pixel budget, in-flight count) checks it.
module tb_upsample_channel_scheduler;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 2;

  logic              system_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        cfg_col_size = '0;
  logic [9:0]        cfg_row_size = '0;
  logic [11:0]       cfg_channels = '0;
  logic [ADDR_W-1:0] cfg_src_addr = '0;
  logic              busy, done, cfg_err, rd_cmd_valid, src_ready, up_feature_valid;
  logic              rd_cmd_ready = 1'b0;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [19:0]       rd_cmd_len;
  logic [7:0]        src_data = '0;
  logic              src_valid = 1'b0;
  logic [7:0]        up_feature;
  logic              up_feature_ready = 1'b0;
  logic [9:0]        up_col_size, up_row_size;
  logic              up_channel_ready = 1'b0;

  upsample_channel_scheduler #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .start(start),
    .cfg_col_size(cfg_col_size), .cfg_row_size(cfg_row_size),
    .cfg_channels(cfg_channels), .cfg_src_addr(cfg_src_addr),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .up_feature(up_feature), .up_feature_valid(up_feature_valid),
    .up_feature_ready(up_feature_ready),
    .up_col_size(up_col_size), .up_row_size(up_row_size),
    .up_channel_ready(up_channel_ready)
  );

  always #5 system_clk = ~system_clk;

  int total = 0;
  int bad   = 0;

  // stimulus knobs (percent probabilities and directed modes)
  int p_cmd = 100, p_src = 100, p_upr = 100, p_chr = 100;
  bit stall5 = 0, withhold = 0;
  int abort_pix = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic run_layer(input logic [9:0] col, input logic [9:0] row,
                           input logic [11:0] ch, input logic [31:0] addr);
    logic [31:0] exp_addr;
    int len, src_rem, fed_m, done_m, pend, cmds, pix, done_at, stall, held;
    bit prev_stall, seen_done, released;
    len = int'(col) * int'(row);
    exp_addr = addr;
    src_rem = 0; fed_m = 0; done_m = 0; pend = 0; cmds = 0; pix = 0;
    done_at = -100; stall = 0; held = 0;
    prev_stall = 0; seen_done = 0; released = 0;
    start = 1'b1; cfg_col_size = col; cfg_row_size = row;
    cfg_channels = ch; cfg_src_addr = addr;
    tick();
    start = 1'b0;
    chk("start_err_clr", cfg_err, 0);
    chk("start_busy", busy, 1);
    chk("start_lat", rd_cmd_valid, 1);
    chk("up_col", up_col_size, col);
    chk("up_row", up_row_size, row);
    for (int cyc = 0; cyc < 5000 && !seen_done; cyc++) begin
      rd_cmd_ready     = stall5 ? (rd_cmd_valid && stall >= 5) : ($urandom_range(99) < p_cmd);
      src_valid        = (src_rem > 0) && ($urandom_range(99) < p_src);
      src_data         = 8'($urandom);
      up_feature_ready = ($urandom_range(99) < p_upr);
      up_channel_ready = (pend > 0) && !(withhold && !released) && ($urandom_range(99) < p_chr);
      #1;
      chk("done", done, cyc == done_at);
      if (done) seen_done = 1;
      chk("busy", busy, 1);
      chk("src_ready", src_ready, (src_rem > 0) && up_feature_ready);
      chk("up_valid", up_feature_valid, (src_rem > 0) && src_valid);
      if (src_valid) chk("pass_data", up_feature, src_data);
      if (prev_stall) chk("cmd_hold", rd_cmd_valid, 1);
      if (rd_cmd_valid) begin
        chk("cmd_addr", rd_cmd_addr, exp_addr);
        chk("cmd_len", rd_cmd_len, len);
        chk("cmd_slot", (fed_m - done_m) < MAX_OUT, 1);
        chk("cmd_count", cmds < int'(ch), 1);
        chk("cmd_src_idle", src_rem == 0, 1);
      end
      if (withhold && !released && fed_m == 2) begin
        held++;
        if (held == 10) begin
          chk("slot_nocmd", rd_cmd_valid, 0);
          chk("slot_srcrdy", src_ready, 0);
          chk("slot_busy", busy, 1);
          released = 1;
        end
      end
      prev_stall = rd_cmd_valid && !rd_cmd_ready;
      if (rd_cmd_valid) stall++;
      if (up_channel_ready) begin
        done_m++; pend--;
        if (done_m == int'(ch)) done_at = cyc + 2;
      end
      if (src_valid && src_ready) begin
        pix++; src_rem--;
        if (src_rem == 0) begin fed_m++; pend++; end
      end
      if (rd_cmd_valid && rd_cmd_ready) begin
        src_rem = len; exp_addr = exp_addr + 32'(len); cmds++; stall = 0;
      end
      if (abort_pix > 0 && pix == abort_pix) return;
      tick();
    end
    up_channel_ready = 1'b0; src_valid = 1'b0;
    if (!seen_done) chk("timeout", 0, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("pix_total", pix, len * int'(ch));
    chk("cmd_total", cmds, ch);
    chk("err_clean", cfg_err, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_cmdv"}, rd_cmd_valid, 0);
    chk({tag, "_srdy"}, src_ready, 0);
    chk({tag, "_upv"}, up_feature_valid, 0);
    chk({tag, "_addr"}, rd_cmd_addr, 0);
    chk({tag, "_len"}, rd_cmd_len, 0);
    chk({tag, "_col"}, up_col_size, 0);
    chk({tag, "_row"}, up_row_size, 0);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // basic layer, everything ready
    run_layer(10'd4, 10'd2, 12'd3, 32'h1000);

    // command handshake held off 5 cycles each
    stall5 = 1; p_src = 70; p_upr = 60; p_chr = 40;
    run_layer(10'd3, 10'd2, 12'd2, 32'h2000);
    stall5 = 0;

    // engine withholds channel_ready until the scheduler sits with two in flight
    withhold = 1; p_src = 100; p_upr = 100; p_chr = 50; p_cmd = 80;
    run_layer(10'd2, 10'd2, 12'd4, 32'h3000);
    withhold = 0;

    // zero-size config
    start = 1'b1; cfg_col_size = 10'd4; cfg_row_size = 10'd0; cfg_channels = 12'd2;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      chk("zc_nocmd", rd_cmd_valid, 0);
      if (done) seen++;
      tick();
    end
    chk("zc_done_once", seen, 1);
    chk("zc_err", cfg_err, 1);
    chk("zc_idle", busy, 0);

    // spurious channel_ready while idle
    run_layer(10'd1, 10'd1, 12'd1, 32'h10);
    up_channel_ready = 1'b1;
    tick();
    up_channel_ready = 1'b0;
    tick();
    chk("idle_chr_err", cfg_err, 1);

    // 1x1 channels, random handshakes; clears the sticky error
    p_cmd = 60; p_src = 60; p_upr = 50; p_chr = 30;
    run_layer(10'd1, 10'd1, 12'd5, 32'h4000);

    for (int n = 0; n < 4; n++) begin
      p_cmd = $urandom_range(90, 30); p_src = $urandom_range(90, 30);
      p_upr = $urandom_range(90, 30); p_chr = $urandom_range(80, 20);
      run_layer(10'($urandom_range(6, 1)), 10'($urandom_range(5, 1)),
                12'($urandom_range(6, 1)), 32'hFFFF_FFF0 + 32'($urandom_range(15)));
    end

    // reset in the middle of a channel
    p_cmd = 100; p_src = 100; p_upr = 100; p_chr = 100;
    abort_pix = 3;
    run_layer(10'd4, 10'd4, 12'd2, 32'h5000);
    abort_pix = 0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    check_reset_vals("arst_edge");
    src_valid = 1'b0; up_channel_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_resume_busy", busy, 0);
    chk("no_resume_cmd", rd_cmd_valid, 0);

    p_cmd = 70; p_src = 80; p_upr = 70; p_chr = 50;
    run_layer(10'd3, 10'd3, 12'd3, 32'h6000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
